// File: rtl/seg7_pkg.sv
// Seven-segment constants shared by the scan driver and its decoder.
// Segment bytes are active-low {a,b,c,d,e,f,g,dp}; the patterns below leave dp dark.
package seg7_pkg;

    localparam logic [7:0] SEG_0   = 8'h03;
    localparam logic [7:0] SEG_1   = 8'h9F;
    localparam logic [7:0] SEG_2   = 8'h25;
    localparam logic [7:0] SEG_3   = 8'h0D;
    localparam logic [7:0] SEG_4   = 8'h99;
    localparam logic [7:0] SEG_5   = 8'h49;
    localparam logic [7:0] SEG_6   = 8'h41;
    localparam logic [7:0] SEG_7   = 8'h1F;
    localparam logic [7:0] SEG_8   = 8'h01;
    localparam logic [7:0] SEG_9   = 8'h09;
    localparam logic [7:0] SEG_DP  = 8'hFE;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    localparam logic [3:0] CODE_ZERO = 4'h0;
    localparam logic [3:0] CODE_MAX  = 4'h9;
    localparam logic [3:0] CODE_DP   = 4'hA;
    localparam logic [3:0] CODE_OFF  = 4'hF;

    typedef enum logic {
        BLINK_SHOW = 1'b0,
        BLINK_HIDE = 1'b1
    } blink_phase_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD-to-segment decode with decimal point merge.
// Codes 0-9 carry the requested dp; 0xA is a lone dp; 0xB-0xF are dark.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    input  logic       dp,
    output logic [7:0] seg
);

    logic [7:0] base;

    always_comb begin
        base = SEG_OFF;
        case (code)
            4'h0:    base = SEG_0;
            4'h1:    base = SEG_1;
            4'h2:    base = SEG_2;
            4'h3:    base = SEG_3;
            4'h4:    base = SEG_4;
            4'h5:    base = SEG_5;
            4'h6:    base = SEG_6;
            4'h7:    base = SEG_7;
            4'h8:    base = SEG_8;
            4'h9:    base = SEG_9;
            default: base = SEG_OFF;
        endcase

        if (code <= CODE_MAX)
            seg = {base[7:1], ~dp};
        else if (code == CODE_DP)
            seg = SEG_DP;
        else
            seg = SEG_OFF;
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed seven-segment scanner with frame-coherent snapshot, anti-ghost
// guard, leading-zero suppression, per-digit blink and global blanking.
module seven_seg_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 2,
    parameter int BLINK_FRAMES = 250,
    parameter int LZ_BLANK     = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   blink_en_i,
    input  logic                    blank_i,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [7:0]              cathode,
    output logic                    frame_tick
);

    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SLOT_W = $clog2(REFRESH_DIV);
    localparam int FR_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [SLOT_W-1:0] GUARD    = SLOT_W'(GUARD_CYCLES);
    localparam logic [FR_W-1:0]   FR_MAX   = FR_W'(BLINK_FRAMES - 1);

    logic [SLOT_W-1:0]       slot_cnt;
    logic [IDX_W-1:0]        idx;
    logic [FR_W-1:0]         frame_cnt;
    blink_phase_t            phase;
    logic [4*NUM_DIGITS-1:0] digits_snap;
    logic [NUM_DIGITS-1:0]   dp_snap;
    logic [NUM_DIGITS-1:0]   blink_snap;

    logic                    slot_wrap;
    logic                    frame_wrap;
    logic                    in_guard;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    zero_run;
    logic [3:0]              cur_code;
    logic                    cur_dp;
    logic                    cur_blink;
    logic                    cur_lz;
    logic [NUM_DIGITS-1:0]   anode_next;
    logic [7:0]              dec_seg;
    logic [7:0]              cathode_next;
    logic                    hide;

    assign slot_wrap  = (slot_cnt == SLOT_MAX);
    assign frame_wrap = slot_wrap && (idx == IDX_MAX);
    assign in_guard   = (slot_cnt < GUARD);

    // lz_mask[k]: digit k and every digit above it hold code 0 in the snapshot
    always_comb begin
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int unsigned k = NUM_DIGITS; k > 0; k--) begin
            zero_run     = zero_run & (digits_snap[4*(k-1) +: 4] == CODE_ZERO);
            lz_mask[k-1] = zero_run;
        end
    end

    always_comb begin
        cur_code   = CODE_OFF;
        cur_dp     = 1'b0;
        cur_blink  = 1'b0;
        cur_lz     = 1'b0;
        anode_next = '1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_code      = digits_snap[4*k +: 4];
                cur_dp        = dp_snap[k];
                cur_blink     = blink_snap[k];
                cur_lz        = lz_mask[k];
                anode_next[k] = 1'b0;
            end
        end
    end

    seg7_decode u_decode (
        .code (cur_code),
        .dp   (cur_dp),
        .seg  (dec_seg)
    );

    // A lit dp keeps an otherwise suppressed leading zero on screen
    always_comb begin
        hide = 1'b0;
        if ((LZ_BLANK != 0) && (idx != '0) && cur_lz && !cur_dp)
            hide = 1'b1;
        if ((phase == BLINK_HIDE) && cur_blink)
            hide = 1'b1;
        cathode_next = hide ? SEG_OFF : dec_seg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt    <= '0;
            idx         <= '0;
            frame_cnt   <= '0;
            phase       <= BLINK_SHOW;
            digits_snap <= '1;
            dp_snap     <= '0;
            blink_snap  <= '0;
            frame_tick  <= 1'b0;
            anode       <= '1;
            cathode     <= SEG_OFF;
        end else begin
            slot_cnt   <= slot_wrap ? '0 : slot_cnt + 1'b1;
            frame_tick <= frame_wrap;

            if (slot_wrap)
                idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;

            if (frame_wrap) begin
                digits_snap <= digits_i;
                dp_snap     <= dp_i;
                blink_snap  <= blink_en_i;
                if (frame_cnt == FR_MAX) begin
                    frame_cnt <= '0;
                    phase     <= (phase == BLINK_SHOW) ? BLINK_HIDE : BLINK_SHOW;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end

            if (blank_i || in_guard) begin
                anode   <= '1;
                cathode <= SEG_OFF;
            end else begin
                anode   <= anode_next;
                cathode <= cathode_next;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver: a cycle model feeds a scoreboard
// that is checked every cycle, plus literal checks of the key scenarios.
module tb_seven_seg_scan_driver;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int GUARD = 1;
    localparam int BF    = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [4*N-1:0] digits_i = '0;
    logic [N-1:0]   dp_i = '0;
    logic [N-1:0]   blink_en_i = '0;
    logic           blank_i = 1'b0;
    logic [N-1:0]   anode;
    logic [7:0]     cathode;
    logic           frame_tick;

    int n_cmp = 0;
    int n_err = 0;

    seven_seg_scan_driver #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (DIV),
        .GUARD_CYCLES (GUARD),
        .BLINK_FRAMES (BF),
        .LZ_BLANK     (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits_i   (digits_i),
        .dp_i       (dp_i),
        .blink_en_i (blink_en_i),
        .blank_i    (blank_i),
        .anode      (anode),
        .cathode    (cathode),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_seg(input int code, input bit dp);
        logic [7:0] s;
        case (code)
            0: s = 8'h03;  1: s = 8'h9F;  2: s = 8'h25;  3: s = 8'h0D;
            4: s = 8'h99;  5: s = 8'h49;  6: s = 8'h41;  7: s = 8'h1F;
            8: s = 8'h01;  9: s = 8'h09;
            10: return 8'hFE;
            default: return 8'hFF;
        endcase
        s[0] = ~dp;
        return s;
    endfunction

    // Reference scan state, advanced on every clock edge
    int       m_slot, m_idx, m_fcnt;
    int       m_code [N];
    bit [N-1:0] m_dp, m_blk;
    bit       m_phase;
    logic [12:0] sb [$];

    always @(posedge clk or negedge rst_n) begin
        logic [N-1:0] e_an;
        logic [7:0]   e_cat;
        bit           z;
        if (!rst_n) begin
            m_slot = 0; m_idx = 0; m_fcnt = 0; m_phase = 0;
            m_dp = '0; m_blk = '0;
            for (int k = 0; k < N; k++) m_code[k] = 15;
            sb.delete();
        end else begin
            e_an  = '1;
            e_cat = 8'hFF;
            if (!blank_i && m_slot >= GUARD) begin
                e_an[m_idx] = 1'b0;
                e_cat = ref_seg(m_code[m_idx], m_dp[m_idx]);
                if (m_idx > 0 && !m_dp[m_idx]) begin
                    z = 1;
                    for (int k = m_idx; k < N; k++) if (m_code[k] != 0) z = 0;
                    if (z) e_cat = 8'hFF;
                end
                if (m_phase && m_blk[m_idx]) e_cat = 8'hFF;
            end
            sb.push_back({(m_slot == DIV-1 && m_idx == N-1), e_an, e_cat});

            if (m_slot == DIV-1) begin
                m_slot = 0;
                if (m_idx == N-1) begin
                    m_idx = 0;
                    for (int k = 0; k < N; k++) m_code[k] = int'(digits_i[4*k +: 4]);
                    m_dp  = dp_i;
                    m_blk = blink_en_i;
                    m_fcnt++;
                    if (m_fcnt == BF) begin
                        m_fcnt  = 0;
                        m_phase = ~m_phase;
                    end
                end else begin
                    m_idx++;
                end
            end else begin
                m_slot++;
            end
        end
    end

    always @(negedge clk) begin
        logic [12:0] e;
        if (rst_n && sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            assert (anode === e[11:8]) else begin
                n_err++;
                $error("FAIL sb_anode: got %b expected %b at %0t", anode, e[11:8], $time);
            end
            n_cmp++;
            assert (cathode === e[7:0]) else begin
                n_err++;
                $error("FAIL sb_cathode: got %h expected %h at %0t", cathode, e[7:0], $time);
            end
            n_cmp++;
            assert (frame_tick === e[12]) else begin
                n_err++;
                $error("FAIL sb_tick: got %b expected %b at %0t", frame_tick, e[12], $time);
            end
        end
    end

    task automatic wait_tick(input string tag);
        bit seen = 0;
        for (int c = 0; c < 64 && !seen; c++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) seen = 1;
        end
        n_cmp++;
        assert (seen) else begin
            n_err++;
            $error("FAIL %s: got no frame_tick expected pulse within 64 cycles", tag);
        end
    endtask

    task automatic get_lit(input string tag, input int d, output logic [7:0] cat);
        logic [N-1:0] want;
        bit seen = 0;
        want = '1;
        want[d] = 1'b0;
        cat = 8'hxx;
        for (int c = 0; c < 64 && !seen; c++) begin
            @(negedge clk);
            if (anode === want) begin
                seen = 1;
                cat  = cathode;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s: got no anode %b expected it within 64 cycles", tag, want);
        end
    endtask

    task automatic check_lit(input string tag, input int d, input logic [7:0] exp);
        logic [7:0] cat;
        get_lit(tag, d, cat);
        n_cmp++;
        assert (cat === exp) else begin
            n_err++;
            $error("FAIL %s: got cathode %h expected %h", tag, cat, exp);
        end
    endtask

    initial begin
        logic [7:0] bc [4];
        int gap;

        // Reset state
        digits_i = 16'h1234;
        #12;
        n_cmp++;
        assert (anode === 4'hF) else begin n_err++; $error("FAIL rst_anode: got %b expected 1111", anode); end
        n_cmp++;
        assert (cathode === 8'hFF) else begin n_err++; $error("FAIL rst_cathode: got %h expected ff", cathode); end
        n_cmp++;
        assert (frame_tick === 1'b0) else begin n_err++; $error("FAIL rst_tick: got %b expected 0", frame_tick); end

        @(negedge clk);
        rst_n = 1'b1;

        // First frame is dark, second shows 1234 (digit 0 = 4)
        check_lit("first_frame_dark", 0, 8'hFF);
        wait_tick("tick_1234");
        check_lit("d0_4", 0, 8'h99);
        check_lit("d1_3", 1, 8'h0D);
        check_lit("d2_2", 2, 8'h25);
        check_lit("d3_1", 3, 8'h9F);

        // Leading-zero suppression, then dp keeps digit 3 visible
        digits_i = 16'h0070;
        dp_i     = 4'b0000;
        wait_tick("tick_0070");
        check_lit("lz_d0", 0, 8'h03);
        check_lit("lz_d1", 1, 8'h1F);
        check_lit("lz_d2", 2, 8'hFF);
        check_lit("lz_d3", 3, 8'hFF);
        dp_i = 4'b1000;
        wait_tick("tick_dp");
        check_lit("lzdp_d2", 2, 8'hFF);
        check_lit("lzdp_d3", 3, 8'h02);

        // Mid-frame input change is not shown until the next frame
        digits_i = 16'h1111;
        dp_i     = 4'b0000;
        wait_tick("tick_1111");
        check_lit("coh_d1", 1, 8'h9F);
        digits_i = 16'h2222;
        check_lit("coh_d2", 2, 8'h9F);
        check_lit("coh_d3", 3, 8'h9F);
        wait_tick("tick_2222");
        check_lit("coh_next", 0, 8'h25);

        // Blink: phase flips every two frames
        digits_i   = 16'h0008;
        blink_en_i = 4'b0001;
        wait_tick("tick_blink");
        for (int f = 0; f < 4; f++) begin
            get_lit("blink_d0", 0, bc[f]);
            wait_tick("tick_blink_f");
        end
        n_cmp++;
        assert (bc[0] !== bc[2]) else begin n_err++; $error("FAIL blink_toggle02: got %h expected not %h", bc[2], bc[0]); end
        n_cmp++;
        assert (bc[1] !== bc[3]) else begin n_err++; $error("FAIL blink_toggle13: got %h expected not %h", bc[3], bc[1]); end
        n_cmp++;
        assert ((bc[0] === 8'h01 || bc[0] === 8'hFF) && (bc[1] === 8'h01 || bc[1] === 8'hFF))
        else begin n_err++; $error("FAIL blink_values: got %h/%h expected 01 or ff", bc[0], bc[1]); end

        // Blank pulse does not disturb scan timing
        blink_en_i = '0;
        wait_tick("tick_pre_blank");
        gap = 0;
        for (int c = 1; c <= 40 && gap == 0; c++) begin
            @(negedge clk);
            if (c >= 6 && c <= 10) begin
                n_cmp++;
                assert (anode === 4'hF) else begin n_err++; $error("FAIL blank_anode: got %b expected 1111 (c=%0d)", anode, c); end
            end
            if (c == 5)  blank_i = 1'b1;
            if (c == 10) blank_i = 1'b0;
            if (frame_tick === 1'b1) gap = c;
        end
        n_cmp++;
        assert (gap == N*DIV) else begin n_err++; $error("FAIL blank_gap: got %0d expected %0d", gap, N*DIV); end

        // Asynchronous reset mid-slot
        digits_i = 16'h1234;
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        assert (anode === 4'hF) else begin n_err++; $error("FAIL arst_anode: got %b expected 1111", anode); end
        n_cmp++;
        assert (cathode === 8'hFF) else begin n_err++; $error("FAIL arst_cathode: got %h expected ff", cathode); end
        n_cmp++;
        assert (frame_tick === 1'b0) else begin n_err++; $error("FAIL arst_tick: got %b expected 0", frame_tick); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_lit("arst_first_dark", 0, 8'hFF);
        wait_tick("tick_after_arst");
        check_lit("arst_d0", 0, 8'h99);
        check_lit("arst_d3", 3, 8'h9F);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
